alu_seq: RTL and testbench

Multi-cycle integer ALU. It is the responder side of the processor's in_valid/out_valid ALU handshake. It accepts a pair of operands plus an RV32I funct3-style opcode, computes the result over a variable number of cycles, and returns the result with a single-cycle out_valid pulse. Add and compare operations are processed DIGIT bits per cycle. Shifts are processed one bit position per cycle.

---
 rtl/alu_seq.sv | 266 ++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Multi-cycle integer ALU, responder side of the in_valid/out_valid handshake.
// Logic ops finish in one edge, add/compare ripple DIGIT bits per edge, and
// shifts move one bit position per edge. The result is presented on out
// together with a single-cycle out_valid pulse.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       op,
  input  logic             op_alt,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy
);

  // Number of DIGIT-wide chunks in one operand and the counter that walks them.
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(N - 1);

  // funct3 encodings.
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SR   = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOGIC = 2'd1,
    ARITH = 2'd2,
    SHIFT = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg,     a_next;      // operand A; doubles as the shift working register
  logic [WIDTH-1:0] b_reg,     b_next;      // operand B as captured (never inverted in place)
  logic [2:0]       op_reg,    op_next;
  logic             alt_reg,   alt_next;    // SRA select, meaningful for op 101 only
  logic             sign_reg,  sign_next;   // MSB of A at capture, used as SRA fill bit
  logic [WIDTH-1:0] acc_reg,   acc_next;    // chunk sums, shifted in from the top
  logic             carry_reg, carry_next;
  logic [CW-1:0]    chunk_reg, chunk_next;
  logic [4:0]       shamt_reg, shamt_next;
  logic [WIDTH-1:0] out_reg,   out_next;
  logic             valid_reg, valid_next;

  // ---------------------------------------------------------------------------
  // Chunk views of the operands
  // ---------------------------------------------------------------------------
  logic [DIGIT-1:0] a_chunk [N];
  logic [DIGIT-1:0] b_chunk [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chunk
      assign a_chunk[gi] = a_reg[gi*DIGIT +: DIGIT];
      assign b_chunk[gi] = b_reg[gi*DIGIT +: DIGIT];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Ripple-add datapath: one chunk per edge
  // ---------------------------------------------------------------------------
  logic [DIGIT-1:0] a_cur;
  logic [DIGIT-1:0] b_cur;
  logic [DIGIT:0]   chunk_sum;
  logic [WIDTH-1:0] acc_shifted;

  // Compares subtract, so the second operand is ~b with the initial carry set.
  assign a_cur = a_chunk[chunk_reg];
  assign b_cur = (op_reg == OP_ADD) ? b_chunk[chunk_reg] : ~b_chunk[chunk_reg];

  assign chunk_sum = {1'b0, a_cur} + {1'b0, b_cur} + {{DIGIT{1'b0}}, carry_reg};

  // After N edges the lowest chunk has been shifted down to bit 0, so the
  // accumulator holds the full sum/difference in natural order.
  assign acc_shifted = (acc_reg >> DIGIT) | (WIDTH'(chunk_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

  // ---------------------------------------------------------------------------
  // Compare decode, valid only on the edge that processes the last chunk
  // ---------------------------------------------------------------------------
  logic diff_msb;
  logic signed_ovf;
  logic slt_bit;
  logic sltu_bit;

  assign diff_msb   = acc_shifted[WIDTH-1];
  assign signed_ovf = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (diff_msb != a_reg[WIDTH-1]);
  assign slt_bit    = diff_msb ^ signed_ovf;
  // a - b borrows exactly when a < b unsigned, i.e. the final carry-out is 0.
  assign sltu_bit   = ~chunk_sum[DIGIT];

  logic [WIDTH-1:0] arith_result;

  // Select the arithmetic result for the captured opcode.
  always_comb begin
    arith_result = acc_shifted;
    case (op_reg)
      OP_SLT:  arith_result = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLTU: arith_result = {{(WIDTH-1){1'b0}}, sltu_bit};
      default: arith_result = acc_shifted;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bitwise logic datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] logic_result;

  // Only XOR, OR and AND ever reach the LOGIC state.
  always_comb begin
    logic_result = a_reg & b_reg;
    case (op_reg)
      OP_XOR:  logic_result = a_reg ^ b_reg;
      OP_OR:   logic_result = a_reg | b_reg;
      OP_AND:  logic_result = a_reg & b_reg;
      default: logic_result = a_reg & b_reg;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single-position shifter
  // ---------------------------------------------------------------------------
  logic             shift_fill;
  logic [WIDTH-1:0] shift_step;

  // Right shifts fill with the captured sign for SRA and with zero for SRL.
  assign shift_fill = alt_reg & sign_reg;

  // Shift the working register by one position in the captured direction.
  always_comb begin
    shift_step = {shift_fill, a_reg[WIDTH-1:1]};
    if (op_reg == OP_SLL) begin
      shift_step = {a_reg[WIDTH-2:0], 1'b0};
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-register logic
  // ---------------------------------------------------------------------------
  // Hold everything by default; only the current state's rules change registers.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    op_next    = op_reg;
    alt_next   = alt_reg;
    sign_next  = sign_reg;
    acc_next   = acc_reg;
    carry_next = carry_reg;
    chunk_next = chunk_reg;
    shamt_next = shamt_reg;
    out_next   = out_reg;
    valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next     = a_in;
          b_next     = b_in;
          op_next    = op;
          alt_next   = op_alt;
          sign_next  = a_in[WIDTH-1];
          acc_next   = '0;
          chunk_next = '0;
          carry_next = (op != OP_ADD);
          shamt_next = b_in[4:0];
          case (op)
            OP_ADD, OP_SLT, OP_SLTU: state_next = ARITH;
            OP_SLL, OP_SR:           state_next = SHIFT;
            default:                 state_next = LOGIC;
          endcase
        end
      end

      LOGIC: begin
        out_next   = logic_result;
        valid_next = 1'b1;
        state_next = IDLE;
      end

      ARITH: begin
        acc_next   = acc_shifted;
        carry_next = chunk_sum[DIGIT];
        chunk_next = chunk_reg + 1'b1;
        if (chunk_reg == LAST_CHUNK) begin
          out_next   = arith_result;
          valid_next = 1'b1;
          state_next = IDLE;
        end
      end

      SHIFT: begin
        if (shamt_reg == 5'd0) begin
          // Zero shift amount: return A untouched after a single edge.
          out_next   = a_reg;
          valid_next = 1'b1;
          state_next = IDLE;
        end else begin
          a_next     = shift_step;
          shamt_next = shamt_reg - 5'd1;
          if (shamt_reg == 5'd1) begin
            out_next   = shift_step;
            valid_next = 1'b1;
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register update with asynchronous reset
  // ---------------------------------------------------------------------------
  // Reset aborts any operation in flight and clears the whole datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      alt_reg   <= 1'b0;
      sign_reg  <= 1'b0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      chunk_reg <= '0;
      shamt_reg <= '0;
      out_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      op_reg    <= op_next;
      alt_reg   <= alt_next;
      sign_reg  <= sign_next;
      acc_reg   <= acc_next;
      carry_reg <= carry_next;
      chunk_reg <= chunk_next;
      shamt_reg <= shamt_next;
      out_reg   <= out_next;
      valid_reg <= valid_next;
    end
  end

  assign out       = out_reg;
  assign out_valid = valid_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: a transaction-level reference model checked against
// the DUT every cycle, plus directed vectors with hand-computed results.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [2:0]  op;
  logic        op_alt;
  logic        in_valid;
  logic [31:0] out;
  logic        out_valid;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic check_en = 1'b0;

  alu_seq #(.WIDTH(32), .DIGIT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_in      (a_in),
    .b_in      (b_in),
    .op        (op),
    .op_alt    (op_alt),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result straight from the instruction semantics.
  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] o, input logic alt);
    logic signed [31:0] sa;
    logic [31:0] r;
    sa = a;
    case (o)
      3'b000: r = a + b;
      3'b001: r = a << b[4:0];
      3'b010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011: r = (a < b) ? 32'd1 : 32'd0;
      3'b100: r = a ^ b;
      3'b101: begin
        if (alt) r = sa >>> b[4:0];
        else     r = a >> b[4:0];
      end
      3'b110: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Edges from capture to completion.
  function automatic int ref_latency(input logic [31:0] b, input logic [2:0] o);
    case (o)
      3'b000, 3'b010, 3'b011: return 4;
      3'b001, 3'b101:         return (b[4:0] == 5'd0) ? 1 : int'(b[4:0]);
      default:                return 1;
    endcase
  endfunction

  // Model state: one outstanding request and a countdown to its completion.
  logic        m_busy = 1'b0;
  int          m_remain = 0;
  logic [31:0] m_res = '0;
  logic [31:0] exp_out = '0;
  logic        exp_valid = 1'b0;

  // Advance the model on each edge, then compare all outputs shortly after.
  always @(posedge clk) begin
    if (rst) begin
      m_busy    = 1'b0;
      m_remain  = 0;
      exp_out   = '0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (!m_busy) begin
        if (in_valid) begin
          m_res    = ref_result(a_in, b_in, op, op_alt);
          m_remain = ref_latency(b_in, op);
          m_busy   = 1'b1;
        end
      end else begin
        m_remain--;
        if (m_remain == 0) begin
          exp_valid = 1'b1;
          exp_out   = m_res;
          m_busy    = 1'b0;
        end
      end
    end
    #1;
    if (check_en) begin
      chk("cycle out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      chk("cycle busy", {31'b0, busy}, {31'b0, m_busy});
      chk("cycle out", out, exp_out);
    end
  end

  // One request; checks latency and result against literal expectations.
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] o, input logic alt,
                        input logic [31:0] exp, input int exp_lat);
    int n;
    logic got;
    @(negedge clk);
    a_in = a; b_in = b; op = o; op_alt = alt; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in = $urandom; b_in = $urandom; op = 3'($urandom_range(0, 7)); op_alt = 1'($urandom_range(0, 1));
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) got = 1'b1;
    end
    $display("txn %-10s a=%h b=%h op=%0d alt=%0d -> out=%h latency=%0d", nm, a, b, o, alt, out, n);
    chk({nm, " latency"}, 32'(n), 32'(exp_lat));
    chk({nm, " out"}, out, exp);
  endtask

  initial begin
    int nv;
    rst = 1'b1; a_in = '0; b_in = '0; op = '0; op_alt = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out", out, 32'h0);
    chk("reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;

    run_op("ADD",      32'h00000005, 32'h00000007, 3'b000, 1'b0, 32'h0000000C, 4);
    run_op("ADD wrap", 32'hFFFFFFFF, 32'h00000001, 3'b000, 1'b0, 32'h00000000, 4);
    run_op("SLT",      32'hFFFFFFFF, 32'h00000001, 3'b010, 1'b0, 32'h00000001, 4);
    run_op("SLTU",     32'hFFFFFFFF, 32'h00000001, 3'b011, 1'b0, 32'h00000000, 4);
    run_op("SLT ovf",  32'h7FFFFFFF, 32'h80000000, 3'b010, 1'b0, 32'h00000000, 4);
    run_op("SLTU lt",  32'h00000003, 32'h80000000, 3'b011, 1'b0, 32'h00000001, 4);
    run_op("SRA",      32'h80000000, 32'h00000004, 3'b101, 1'b1, 32'hF8000000, 4);
    run_op("SRL",      32'h80000000, 32'h00000004, 3'b101, 1'b0, 32'h08000000, 4);
    run_op("SLL",      32'h00000001, 32'h00000023, 3'b001, 1'b0, 32'h00000008, 3);
    run_op("SRL sh0",  32'h12345678, 32'hFFFFFFE0, 3'b101, 1'b0, 32'h12345678, 1);
    run_op("SLL sh31", 32'h00000003, 32'h0000001F, 3'b001, 1'b0, 32'h80000000, 31);
    run_op("XOR",      32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 1'b0, 32'h0FF00FF0, 1);
    run_op("OR",       32'hF0F0F0F0, 32'hFF00FF00, 3'b110, 1'b0, 32'hFFF0FFF0, 1);
    run_op("AND",      32'hF0F0F0F0, 32'hFF00FF00, 3'b111, 1'b1, 32'hF000F000, 1);

    // Reset two edges into an ADD: outputs clear immediately, no completion.
    @(negedge clk);
    a_in = 32'h11111111; b_in = 32'h22222222; op = 3'b000; op_alt = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    $display("txn RST mid-ADD -> out=%h out_valid=%0d busy=%0d", out, out_valid, busy);
    chk("abort out", out, 32'h0);
    chk("abort out_valid", {31'b0, out_valid}, 32'h0);
    chk("abort busy", {31'b0, busy}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op("ADD post", 32'h12345678, 32'h0FEDCBA9, 3'b000, 1'b0, 32'h22222221, 4);

    // in_valid held high: ignored while busy, then captured right after out_valid.
    @(negedge clk);
    a_in = 32'h00000001; b_in = 32'h00000002; op = 3'b000; op_alt = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    a_in = 32'hF0F0F0F0; b_in = 32'hFF00FF00; op = 3'b100;
    nv = 0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (out_valid) nv++;
      if (e == 4) begin
        $display("txn B2B ADD -> out=%h out_valid=%0d", out, out_valid);
        chk("b2b first valid", {31'b0, out_valid}, 32'h1);
        chk("b2b first out", out, 32'h00000003);
      end
      if (e == 6) begin
        $display("txn B2B XOR -> out=%h out_valid=%0d", out, out_valid);
        chk("b2b second valid", {31'b0, out_valid}, 32'h1);
        chk("b2b second out", out, 32'h0FF00FF0);
        in_valid = 1'b0;
      end
    end
    chk("b2b valid count", 32'(nv), 32'd2);

    repeat (2) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
